csa_wide_add_sequencer: RTL and testbench
=========================================

Name: csa_wide_add_sequencer

Overview:
- Multi-cycle controller that performs a WORDS×SLICE_W-bit add/subtract on one shared SLICE_W-bit carry-select adder, one slice per clock, LSB slice first.
- Drives the adder's A/B/carry-in ports, captures its sum and carry-out, and chains the carry through a register between beats.
- Sits between a requester (start/done handshake) and the existing 16-bit carry-select adder instance, which stays purely combinational.

Parameters:
- WORDS, 4, number of slices per operation (≥2); total width N = WORDS*SLICE_W.
- SLICE_W, 16, width of the shared adder.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op_a  input  N  operand A; sampled on the accepted start edge.
- op_b  input  N  operand B; sampled on the accepted start edge.
- carry_in  input  1  initial carry for add; ignored when sub=1.
- sub  input  1  1 = A−B (B inverted, initial carry forced to 1); sampled with start.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse when result/carry_out are valid.
- result  output  N  registered sum; holds until the next accepted start.
- carry_out  output  1  final carry (sub: 1 = no borrow); holds like result.
- adder_a  output  SLICE_W  slice of A to the shared adder.
- adder_b  output  SLICE_W  slice of B, or of ~B when sub=1.
- adder_cin  output  1  chained carry to the shared adder.
- adder_sum  input  SLICE_W  shared adder sum, combinational.
- adder_cout  input  1  shared adder carry-out, combinational.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, carry_out, adder_a, adder_b and adder_cin = 0; result=0; beat counter=0; operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - adder_* outputs driven 0.
  - On start=1: latch op_a, op_b (inverted if sub), set carry register = sub ? 1 : carry_in, clear counter k, clear result, go to RUN.
- RUN, beat k = 0..WORDS-1:
  - Combinationally drive adder_a = A[k], adder_b = B'[k], adder_cin = carry register.
  - At the clock edge: result[k] <= adder_sum; carry register <= adder_cout; k <= k+1.
  - After beat WORDS-1, go to DONE.
- DONE:
  - done=1 for exactly one cycle; carry_out = carry register; adder_* outputs driven 0.
  - Go to IDLE on the next edge.
- Latency: start accepted at edge E; beats occupy the cycles after edges E..E+WORDS-1; done is high in the cycle after edge E+WORDS, i.e. WORDS+1 cycles after acceptance.
- start while busy (RUN or DONE) is ignored; there is no queuing.
- Back-to-back operation: start in the first IDLE cycle after DONE is accepted. Maximum throughput is one operation per WORDS+2 cycles.
- Counter width is clog2(WORDS); no wrap occurs, because the FSM exits at WORDS-1.
- Result slices not yet written during RUN read 0. Consumers use result only when done=1, or afterwards while in IDLE.
- Reset mid-operation aborts immediately to reset values. No partial result survives, and the next start behaves normally.

Optional Feature:
- Macro: CSA_SEQ_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit): signed two's-complement overflow of the N-bit operation.
  - Computed at the final beat as (A_msb == B'_msb) && (adder_sum_msb != A_msb) and registered with carry_out.
  - Reset value 0; holds until the next accepted start.
- Not defined: port absent; no overflow logic.

Test Plan (WORDS=4, SLICE_W=16):
- Reset: hold rst_n=0 with start=1 → busy=0, done=0, result=0, carry_out=0, adder_a=adder_b=0, adder_cin=0. Release → stays IDLE until start is sampled high.
- Add with carry ripple: A=0x0000_0000_0000_FFFF, B=0x1, cin=0, sub=0 → adder_cin per beat 0,1,0,0; done 5 cycles after the accepting edge; result=0x0000_0000_0001_0000, carry_out=0.
- Full carry chain: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 → adder_cin per beat 1,1,1,1; result=0, carry_out=1; overflow=0 when CSA_SEQ_OVERFLOW_EN is defined.
- Subtract: A=5, B=7, sub=1 → result=0xFFFF_FFFF_FFFF_FFFE, carry_out=0. Then A=7, B=5, sub=1 → result=2, carry_out=1.
- Busy protection and overflow: start A=0x7FFF_FFFF_FFFF_FFFF, B=1 → result=0x8000_0000_0000_0000, carry_out=0, overflow=1 (if enabled). A second start with A=B=0x1234 pulsed during beat 2 is ignored: no extra done pulse, result unchanged.
- Reset mid-run: start A=0x1_0001, B=0x1_0001; drop rst_n during beat 2 → outputs return to reset values at once. New start with A=10, B=11, cin=1 → result=22, carry_out=0.

Source files
------------

// File: rtl/csa_wide_add_sequencer_if.sv
// Requester and shared-adder signal bundle for csa_wide_add_sequencer.
// CSA_SEQ_OVERFLOW_EN adds the signed overflow flag.
interface csa_wide_add_sequencer_if #(
  parameter int WORDS   = 4,
  parameter int SLICE_W = 16
);
  localparam int N = WORDS * SLICE_W;

  logic               start;
  logic [N-1:0]       op_a;
  logic [N-1:0]       op_b;
  logic               carry_in;
  logic               sub;
  logic               busy;
  logic               done;
  logic [N-1:0]       result;
  logic               carry_out;
  logic [SLICE_W-1:0] adder_a;
  logic [SLICE_W-1:0] adder_b;
  logic               adder_cin;
  logic [SLICE_W-1:0] adder_sum;
  logic               adder_cout;
`ifdef CSA_SEQ_OVERFLOW_EN
  logic               overflow;

  modport slave (
    input  start, op_a, op_b, carry_in, sub, adder_sum, adder_cout,
    output busy, done, result, carry_out, adder_a, adder_b, adder_cin, overflow
  );
  modport master (
    output start, op_a, op_b, carry_in, sub, adder_sum, adder_cout,
    input  busy, done, result, carry_out, adder_a, adder_b, adder_cin, overflow
  );
`else
  modport slave (
    input  start, op_a, op_b, carry_in, sub, adder_sum, adder_cout,
    output busy, done, result, carry_out, adder_a, adder_b, adder_cin
  );
  modport master (
    output start, op_a, op_b, carry_in, sub, adder_sum, adder_cout,
    input  busy, done, result, carry_out, adder_a, adder_b, adder_cin
  );
`endif
endinterface

// File: rtl/csa_wide_add_sequencer.sv
// Sequences a WORDS*SLICE_W-bit add/sub through one shared SLICE_W-bit adder, LSB slice first.
// Optional CSA_SEQ_OVERFLOW_EN adds a registered signed-overflow flag.
module csa_wide_add_sequencer #(
  parameter int WORDS   = 4,
  parameter int SLICE_W = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  csa_wide_add_sequencer_if.slave  bus
);
  localparam int N  = WORDS * SLICE_W;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [N-1:0]       a_q, b_q, res_q;
  logic               cy_q, cout_q;
  logic [KW-1:0]      k_q;
  logic               last;
  logic [SLICE_W-1:0] add_a, add_b;
  logic               add_cin;

  assign last = (k_q == KW'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Adder ports are only live during RUN so the shared adder sees zeros otherwise.
  always_comb begin
    state_nx = state;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nx = RUN;
      RUN: begin
        add_a   = a_q[k_q*SLICE_W +: SLICE_W];
        add_b   = b_q[k_q*SLICE_W +: SLICE_W];
        add_cin = cy_q;
        if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef CSA_SEQ_OVERFLOW_EN
  logic ovf_q;
  // Signed overflow: operands agree in sign but the top slice's sum does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ovf_q <= 1'b0;
    else if (state == IDLE && bus.start) ovf_q <= 1'b0;
    else if (state == RUN && last)
      ovf_q <= (a_q[N-1] == b_q[N-1]) && (bus.adder_sum[SLICE_W-1] != a_q[N-1]);
  end
  assign bus.overflow = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cy_q   <= 1'b0;
      cout_q <= 1'b0;
      k_q    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_q    <= bus.op_a;
          b_q    <= bus.sub ? ~bus.op_b : bus.op_b;
          cy_q   <= bus.sub | bus.carry_in;
          res_q  <= '0;
          cout_q <= 1'b0;
          k_q    <= '0;
        end
        RUN: begin
          res_q[k_q*SLICE_W +: SLICE_W] <= bus.adder_sum;
          cy_q <= bus.adder_cout;
          if (last) cout_q <= bus.adder_cout;
          else      k_q    <= k_q + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.result    = res_q;
  assign bus.carry_out = cout_q;
  assign bus.adder_a   = add_a;
  assign bus.adder_b   = add_b;
  assign bus.adder_cin = add_cin;
endmodule

// File: tb/tb_csa_wide_add_sequencer.sv
// Random and directed bench for csa_wide_add_sequencer against an arithmetic model.
// Build with CSA_SEQ_OVERFLOW_EN defined to also cover the overflow flag.
module tb_csa_wide_add_sequencer;
  localparam int WORDS   = 4;
  localparam int SLICE_W = 16;
  localparam int N       = WORDS * SLICE_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  csa_wide_add_sequencer_if #(.WORDS(WORDS), .SLICE_W(SLICE_W)) bus();
  csa_wide_add_sequencer #(.WORDS(WORDS), .SLICE_W(SLICE_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the existing combinational carry-select adder.
  assign {bus.adder_cout, bus.adder_sum} =
    {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {{SLICE_W{1'b0}}, bus.adder_cin};

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] low_mask(input int slices);
    logic [N-1:0] ones;
    ones = '1;
    return ones >> (N - SLICE_W * slices);
  endfunction

  // Model: phase -1 idle, 0..WORDS-1 beat index, WORDS the done cycle.
  int           phase = -1;
  logic [N-1:0] mA = '0, mB = '0, fin = '0, hold = '0;
  logic         mc = 1'b0, fcout = 1'b0, fovf = 1'b0, hcout = 1'b0, hovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = -1; hold = '0; hcout = 1'b0; hovf = 1'b0;
    end else if (phase < 0) begin
      if (bus.start) begin
        mA = bus.op_a;
        mB = bus.sub ? ~bus.op_b : bus.op_b;
        mc = bus.sub | bus.carry_in;
        {fcout, fin} = {1'b0, mA} + {1'b0, mB} + {{N{1'b0}}, mc};
        fovf  = (mA[N-1] == mB[N-1]) && (fin[N-1] != mA[N-1]);
        phase = 0;
      end
    end else if (phase < WORDS) begin
      phase++;
    end else begin
      phase = -1; hold = fin; hcout = fcout; hovf = fovf;
    end
  end

  logic [N:0]   t;
  logic [N-1:0] m;
  always @(negedge clk) begin
    chk("busy", N'(bus.busy), N'(phase >= 0));
    chk("done", N'(bus.done), N'(phase == WORDS));
    if (phase >= 0 && phase < WORDS) begin
      // Carry into slice k is the carry out of the low k slices of the whole sum.
      m = low_mask(phase);
      t = {1'b0, mA & m} + {1'b0, mB & m} + {{N{1'b0}}, mc};
      chk("adder_a", N'(bus.adder_a), N'(mA[phase*SLICE_W +: SLICE_W]));
      chk("adder_b", N'(bus.adder_b), N'(mB[phase*SLICE_W +: SLICE_W]));
      chk("adder_cin", N'(bus.adder_cin), N'(t[phase*SLICE_W]));
    end else begin
      chk("adder_a_idle", N'(bus.adder_a), '0);
      chk("adder_b_idle", N'(bus.adder_b), '0);
      chk("adder_cin_idle", N'(bus.adder_cin), '0);
    end
    chk("result", bus.result, (phase < 0) ? hold : (fin & low_mask(phase)));
    if (phase < 0)           chk("carry_out_hold", N'(bus.carry_out), N'(hcout));
    else if (phase == WORDS) chk("carry_out", N'(bus.carry_out), N'(fcout));
`ifdef CSA_SEQ_OVERFLOW_EN
    if (phase < 0)           chk("overflow_hold", N'(bus.overflow), N'(hovf));
    else if (phase == WORDS) chk("overflow", N'(bus.overflow), N'(fovf));
`endif
  end

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input logic s);
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.carry_in = c; bus.sub = s;
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        input logic s, output logic [N-1:0] r, output logic co,
                        output logic ov, output logic [WORDS-1:0] cins, output int lat);
    @(posedge clk); #2 drive(a, b, c, s);
    @(posedge clk); #2 bus.start = 1'b0;
    lat  = -1;
    cins = '0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j < WORDS) cins[j] = bus.adder_cin;
      if (bus.done) begin lat = j + 1; break; end
    end
    chk("done_seen", N'(lat > 0), N'(1));
    r  = bus.result;
    co = bus.carry_out;
`ifdef CSA_SEQ_OVERFLOW_EN
    ov = bus.overflow;
`else
    ov = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]     r, a, b, e;
    logic             co, ov, c, s;
    logic [WORDS-1:0] cins;
    int               lat, dones;

    rst_n = 1'b0;
    drive(64'hDEAD_BEEF_1234_5678, 64'h1111_2222_3333_4444, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", N'(bus.busy), '0);
    chk("rst_done", N'(bus.done), '0);
    chk("rst_result", bus.result, '0);
    chk("rst_carry_out", N'(bus.carry_out), '0);
    chk("rst_adder_a", N'(bus.adder_a), '0);
    chk("rst_adder_cin", N'(bus.adder_cin), '0);
    #1 bus.start = 1'b0; rst_n = 1'b1;
    repeat (3) begin @(negedge clk); chk("idle_after_rst", N'(bus.busy), '0); end

    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, r, co, ov, cins, lat);
    chk("ripple_result", r, 64'h0000_0000_0001_0000);
    chk("ripple_cout", N'(co), '0);
    chk("ripple_cins", N'(cins), N'(4'b0010));
    chk("ripple_latency", N'(lat), N'(5));

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, r, co, ov, cins, lat);
    chk("chain_result", r, '0);
    chk("chain_cout", N'(co), N'(1));
    chk("chain_cins", N'(cins), N'(4'b1111));
`ifdef CSA_SEQ_OVERFLOW_EN
    chk("chain_ovf", N'(ov), '0);
`endif

    run_op(64'd5, 64'd7, 1'b0, 1'b1, r, co, ov, cins, lat);
    chk("sub_neg_result", r, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_neg_cout", N'(co), '0);
    run_op(64'd7, 64'd5, 1'b0, 1'b1, r, co, ov, cins, lat);
    chk("sub_pos_result", r, 64'd2);
    chk("sub_pos_cout", N'(co), N'(1));

    // A stray start during beat 2 must be ignored.
    @(posedge clk); #2 drive(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    @(posedge clk); #2 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 drive(64'h1234, 64'h1234, 1'b0, 1'b0);
    @(posedge clk); #2 bus.start = 1'b0;
    lat = -1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (bus.done) begin lat = j; break; end
    end
    chk("busy_done_seen", N'(lat >= 0), N'(1));
    chk("ovf_case_result", bus.result, 64'h8000_0000_0000_0000);
    chk("ovf_case_cout", N'(bus.carry_out), '0);
`ifdef CSA_SEQ_OVERFLOW_EN
    chk("ovf_case_ovf", N'(bus.overflow), N'(1));
`endif
    dones = 0;
    repeat (8) begin @(negedge clk); if (bus.done) dones++; end
    chk("no_extra_done", N'(dones), '0);
    chk("result_held", bus.result, 64'h8000_0000_0000_0000);

    // Reset during beat 2 aborts the operation immediately.
    @(posedge clk); #2 drive(64'h1_0001, 64'h1_0001, 1'b0, 1'b0);
    @(posedge clk); #2 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", N'(bus.busy), '0);
    chk("midrst_done", N'(bus.done), '0);
    chk("midrst_result", bus.result, '0);
    chk("midrst_adder_a", N'(bus.adder_a), '0);
    chk("midrst_adder_cin", N'(bus.adder_cin), '0);
    @(posedge clk); #2 rst_n = 1'b1;
    run_op(64'd10, 64'd11, 1'b1, 1'b0, r, co, ov, cins, lat);
    chk("after_rst_result", r, 64'd22);
    chk("after_rst_cout", N'(co), '0);

    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 5 == 0) b = ~a;
      c = 1'(($urandom >> 3) & 1);
      s = 1'(($urandom >> 7) & 1);
      e = a + (s ? ~b : b) + {{(N-1){1'b0}}, s | c};
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_op(a, b, c, s, r, co, ov, cins, lat);
      chk("rand_result", r, e);
      chk("rand_latency", N'(lat), N'(WORDS + 1));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
